// File: rtl/index_sequencer.sv
// index_sequencer: job front end for the matrix coprocessor.
// Reads the config word, walks (row, col) indices and owns the memory port.
module index_sequencer #(
    parameter int cell_width      = 32,
    parameter int index_width     = 8,
    parameter int width           = 96,
    parameter int memory_size_log = 8
) (
    input  logic                       in_clk,
    input  logic                       in_reset,
    input  logic                       in_start,
    input  logic                       in_result_ready,
    input  logic                       in_request,
    input  logic [width-1:0]           in_mem_data,
    input  logic [memory_size_log-1:0] in_proc_mem_address,
    input  logic                       in_proc_mem_read_en,
    input  logic                       in_proc_mem_write_en,
    input  logic [width-1:0]           in_proc_mem_data,
    output logic [index_width-1:0]     out_row_index,
    output logic [index_width-1:0]     out_col_index,
    output logic                       out_index_ready,
    output logic [index_width-1:0]     out_mu,
    output logic [cell_width-1:0]      out_config,
    output logic                       out_grant,
    output logic [memory_size_log-1:0] out_mem_address,
    output logic                       out_mem_read_en,
    output logic                       out_mem_write_en,
    output logic [width-1:0]           out_mem_data,
    output logic [width-1:0]           out_proc_mem_data,
    output logic                       out_busy,
    output logic                       out_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_RD,
        S_CFG_WAIT,
        S_ISSUE,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic                   r_first;
    logic [cell_width-1:0]  r_config;
    logic [index_width-1:0] r_row;
    logic [index_width-1:0] r_col;
    logic                   r_index_ready;
    logic                   r_busy;
    logic                   r_done;

    logic [index_width-1:0] w_col_last;
    logic [index_width-1:0] w_row_last;
    logic                   w_empty;

    assign w_col_last = index_width'(r_config[15:8]) - index_width'(1);
    assign w_row_last = index_width'(r_config[7:0]) - index_width'(1);
    assign w_empty    = (in_mem_data[15:8] == 8'd0) || (in_mem_data[7:0] == 8'd0);

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_state       <= S_IDLE;
            r_first       <= 1'b0;
            r_config      <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_index_ready <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_start) begin
                        r_state <= S_CFG_RD;
                        r_busy  <= 1'b1;
                    end
                end
                S_CFG_RD: r_state <= S_CFG_WAIT;
                S_CFG_WAIT: begin
                    r_config <= in_mem_data[cell_width-1:0];
                    r_row    <= '0;
                    r_col    <= '0;
                    if (w_empty) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state       <= S_ISSUE;
                        r_index_ready <= 1'b1;
                        r_first       <= 1'b1;
                    end
                end
                // first ISSUE cycle ignores result_ready left over from the last index
                S_ISSUE: begin
                    if (r_first) begin
                        r_first <= 1'b0;
                    end else if (in_result_ready) begin
                        r_state       <= S_RELEASE;
                        r_index_ready <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    if (r_col == w_col_last && r_row == w_row_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        if (r_col == w_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + index_width'(1);
                        end else begin
                            r_col <= r_col + index_width'(1);
                        end
                        r_state       <= S_ISSUE;
                        r_index_ready <= 1'b1;
                        r_first       <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        out_mem_address  = '0;
        out_mem_read_en  = 1'b0;
        out_mem_write_en = 1'b0;
        out_mem_data     = '0;
        out_grant        = 1'b0;
        case (r_state)
            S_CFG_RD: out_mem_read_en = 1'b1;
            S_ISSUE: begin
                out_mem_address  = in_proc_mem_address;
                out_mem_read_en  = in_proc_mem_read_en;
                out_mem_write_en = in_proc_mem_write_en;
                out_mem_data     = in_proc_mem_data;
                out_grant        = in_request;
            end
            default: ;
        endcase
    end

    assign out_row_index     = r_row;
    assign out_col_index     = r_col;
    assign out_index_ready   = r_index_ready;
    assign out_mu            = index_width'(r_config[23:16]);
    assign out_config        = r_config;
    assign out_proc_mem_data = in_mem_data;
    assign out_busy          = r_busy;
    assign out_done          = r_done;

endmodule
